pmu_event_counters: RTL

//  Bank of per-event counters that consumes the routed event vector produced by the PMU event

---
 rtl/pmu_event_counters_if.sv | 28 ++
 rtl/pmu_event_counters.sv | 72 +++++++
 2 files changed

// File: rtl/pmu_event_counters_if.sv
// PMU counter register-side bus: write port, overflow clear, irq mask in;
// counter values, sticky overflow flags and irq out. slave = counter bank.
interface pmu_event_counters_if #(
  parameter int N_COUNTERS    = 24,
  parameter int COUNTER_WIDTH = 32,
  parameter int IDX_W         = $clog2(N_COUNTERS)
);
  logic                                wr_en_i;
  logic [IDX_W-1:0]                    wr_idx_i;
  logic [COUNTER_WIDTH-1:0]            wr_data_i;
  logic [N_COUNTERS-1:0]               ovf_clr_i;
  logic [N_COUNTERS-1:0]               irq_mask_i;
  logic [N_COUNTERS*COUNTER_WIDTH-1:0] counters_o;
  logic [N_COUNTERS-1:0]               ovf_o;
  logic                                irq_o;

  modport master (
    output wr_en_i, wr_idx_i, wr_data_i,
    output ovf_clr_i, irq_mask_i,
    input  counters_o, ovf_o, irq_o
  );

  modport slave (
    input  wr_en_i, wr_idx_i, wr_data_i,
    input  ovf_clr_i, irq_mask_i,
    output counters_o, ovf_o, irq_o
  );
endinterface

// File: rtl/pmu_event_counters.sv
// PMU event counter bank: registered event pipe, per-counter increment with
// write/clear precedence, sticky overflow flags and masked level irq.
// Ports: clk_i, rstn_i (async low), en_i, clear_i, events_i, bus (slave).
// Option: PMU_SATURATE_EN makes counters saturate at all-ones instead of wrap.
module pmu_event_counters #(
  parameter int N_COUNTERS    = 24,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [N_COUNTERS-1:0] events_i,
  pmu_event_counters_if.slave   bus
);
  localparam int IDX_W = $clog2(N_COUNTERS);
  localparam logic [COUNTER_WIDTH-1:0] ONES = '1;

  logic [N_COUNTERS-1:0]    event_q;
  logic [COUNTER_WIDTH-1:0] cnt_q [N_COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt_d [N_COUNTERS];
  logic [N_COUNTERS-1:0]    ovf_q, ovf_d;
  logic                     irq_q, irq_d;

  always_comb begin
    // A wrap in the same cycle re-sets the flag after the w1c.
    ovf_d = ovf_q & ~bus.ovf_clr_i;
    for (int i = 0; i < N_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.wr_en_i && bus.wr_idx_i == IDX_W'(i)) begin
        cnt_d[i] = bus.wr_data_i;
      end else if (event_q[i] && en_i) begin
        if (cnt_q[i] == ONES) begin
          ovf_d[i] = 1'b1;
`ifdef PMU_SATURATE_EN
          cnt_d[i] = ONES;
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
        end
      end
      if (clear_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
    end
    irq_d = |(ovf_d & bus.irq_mask_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      event_q <= '0;
      cnt_q   <= '{default: '0};
      ovf_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= clear_i ? '0 : events_i;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  for (genvar g = 0; g < N_COUNTERS; g++) begin : g_out
    assign bus.counters_o[g*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q[g];
  end

  assign bus.ovf_o = ovf_q;
  assign bus.irq_o = irq_q;
endmodule
